// File: rtl/glb_buffer_bank.sv
// Global buffer bank: captures (id, data) words from the writer and
// streams a requested prefix of them to the PE column multicast network.
module glb_buffer_bank #(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_COL     = 8,
   parameter int BUFFER_SIZE = 512
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [$clog2(BUFFER_SIZE)-1:0]   wr_addr,
   input  logic [$clog2(NUM_COL):0]         wr_id,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic                             clear,
   input  logic                             start,
   input  logic [$clog2(BUFFER_SIZE):0]     rd_len,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [$clog2(NUM_COL):0]         out_id,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic                             out_last,
   output logic                             busy,
   output logic [$clog2(BUFFER_SIZE):0]     fill_count,
   output logic                             wr_err,
   output logic                             rd_err
);

   localparam int AW = $clog2(BUFFER_SIZE);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(NUM_COL) + 1;
   localparam int EW = IW + DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      PREFETCH,
      STREAM
   } state_t;

   state_t state, state_nxt;

   logic [EW-1:0] mem [BUFFER_SIZE];

   // rd_addr always points at the word currently presented (or being fetched)
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] last_idx;
   logic          hs;
   logic          at_last;
   logic          start_ok;
   logic          idle;
   logic [CW-1:0] wr_top;
   logic [CW-1:0] fill_base;

   assign idle      = (state == IDLE);
   assign out_valid = (state == STREAM);
   assign busy      = !idle;
   assign hs        = out_valid & out_ready;
   assign at_last   = ({1'b0, rd_addr} == last_idx);
   assign start_ok  = (rd_len != '0) && (rd_len <= fill_count);
   assign wr_top    = {1'b0, wr_addr} + CW'(1);
   assign fill_base = clear ? '0 : fill_count;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: one fetch cycle, then stream until the final handshake
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start && start_ok) state_nxt = PREFETCH;
         PREFETCH: state_nxt = STREAM;
         STREAM:   if (hs && at_last) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Storage array; writes are only honoured while idle
   always_ff @(posedge clk) begin
      if (wr_en && idle) mem[wr_addr] <= {wr_id, wr_data};
   end

   // Read side: the output register is the RAM's registered read port,
   // loaded with the next entry on each handshake so streaming has no bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr  <= '0;
         last_idx <= '0;
         out_id   <= '0;
         out_data <= '0;
         out_last <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && start_ok) begin
                  rd_addr  <= '0;
                  last_idx <= rd_len - CW'(1);
               end
            end
            PREFETCH: begin
               {out_id, out_data} <= mem[rd_addr];
               out_last           <= (last_idx == '0);
            end
            STREAM: begin
               if (hs) begin
                  if (at_last) begin
                     out_last <= 1'b0;
                  end else begin
                     rd_addr            <= rd_addr + AW'(1);
                     {out_id, out_data} <= mem[rd_addr + AW'(1)];
                     out_last <= (({1'b0, rd_addr} + CW'(1)) == last_idx);
                  end
               end
            end
            default: out_last <= 1'b0;
         endcase
      end
   end

   // Fill tracking and error pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_count <= '0;
         wr_err     <= 1'b0;
         rd_err     <= 1'b0;
      end else begin
         wr_err <= wr_en && !idle;
         rd_err <= start && idle && !start_ok;
         if (idle) begin
            if (wr_en)
               fill_count <= (wr_top > fill_base) ? wr_top : fill_base;
            else if (clear)
               fill_count <= '0;
         end
      end
   end

endmodule

// File: doc/glb_buffer_bank.md
Name: glb_buffer_bank

Overview:
- Global buffer storage stage directly downstream of the buffer writer. It captures (id, data) words at writer-supplied addresses.
- It then streams a requested number of consecutive entries, from address 0 upward, to the PE column multicast network over a valid/ready interface.
- The id field travels with each data word so downstream column filters can match their own column id.

Parameters:
DATA_WIDTH, 16, width of each stored data word
NUM_COL, 8, number of PE columns; id field is $clog2(NUM_COL)+1 bits
BUFFER_SIZE, 512, number of entries; address is $clog2(BUFFER_SIZE) bits

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write strobe from writer (writer's load)
wr_addr  in  $clog2(BUFFER_SIZE)  write address
wr_id  in  $clog2(NUM_COL)+1  column id tag to store
wr_data  in  DATA_WIDTH  data word to store
clear  in  1  pulse: reset fill_count to 0
start  in  1  pulse: begin streaming rd_len entries
rd_len  in  $clog2(BUFFER_SIZE)+1  number of entries to stream
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts word
out_id  out  $clog2(NUM_COL)+1  id of current word
out_data  out  DATA_WIDTH  data of current word
out_last  out  1  current word is the final one of the stream
busy  out  1  high from start acceptance until the final handshake completes
fill_count  out  $clog2(BUFFER_SIZE)+1  highest written address + 1
wr_err  out  1  one-cycle pulse: write dropped
rd_err  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset (async, rst=1):
  - State IDLE; fill_count=0.
  - out_valid, out_last, busy, wr_err, rd_err are 0; out_id and out_data are 0.
  - Memory contents are not reset.
- States: IDLE, PREFETCH, STREAM.
- Writes:
  - In IDLE, a cycle with wr_en=1 stores {wr_id, wr_data} at mem[wr_addr].
  - In that same cycle, fill_count <= max(fill_count, wr_addr+1).
  - In PREFETCH or STREAM, a write is dropped and wr_err pulses high on the next cycle.
- Clear:
  - In IDLE, clear sets fill_count to 0 next cycle.
  - Clear is ignored in other states.
  - If clear and wr_en occur together in IDLE, fill_count becomes wr_addr+1.
- Start:
  - Evaluated only in IDLE.
  - Accepted if 1 <= rd_len <= fill_count, where fill_count is the value before any same-cycle write.
  - If rejected, rd_err pulses on the next cycle and the state stays IDLE.
  - If accepted at edge T:
    - busy=1 from T+1.
    - State is PREFETCH at T+1.
    - out_valid=1 at T+2, carrying mem[0].
  - A start seen outside IDLE is ignored silently.
- STREAM:
  - out_id and out_data hold stable while out_valid=1 and out_ready=0.
  - Each handshake (out_valid & out_ready) advances to the next address.
  - With out_ready held high, one word transfers per cycle with no bubbles. This needs a prefetch/skid register behind the synchronous RAM read.
  - out_last=1 exactly with entry rd_len-1.
  - On the last handshake, the next cycle has out_valid=0, out_last=0, busy=0 and state IDLE.
- rd_len=1: the single word has out_last=1 at T+2.
- Read counter: $clog2(BUFFER_SIZE)+1 bits, so rd_len=BUFFER_SIZE streams entries 0..BUFFER_SIZE-1 without wrap.
- A write to the same address as an entry already queued is impossible, because writes are blocked outside IDLE.
- Reset mid-stream: aborts immediately to the reset values above. The consumer must discard any partial stream.

Test Plan:
- Write addr 0..8 with ids 1..9, data 0x10..0x18; then start with rd_len=9 and out_ready=1 -> fill_count=9, out_valid at T+2, nine consecutive words matching, out_last on the 9th, busy low the cycle after.
- Same fill, stream with out_ready toggling 1,0,0,1,... -> out_data/out_id hold during stalls, no word lost or duplicated, order 0x10..0x18.
- fill_count=4, start with rd_len=5 -> rd_err pulse, no out_valid; start with rd_len=0 -> rd_err pulse.
- During streaming, wr_en=1 at addr 2 with data 0xFF -> wr_err pulse, streamed word 2 unchanged, fill_count unchanged.
- Write all BUFFER_SIZE=512 entries, start with rd_len=512 -> fill_count=512, 512 words, out_last on address 511, no wrap.
- Assert rst at the 3rd handshake of a 9-word stream -> out_valid=0 and busy=0 immediately, fill_count=0; after rewriting and starting again, the stream begins at entry 0.
